// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the character VRAM arbiter: FSM state encoding and
// byte-lane constants used for CPU write strobes.
package vram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACCESS,
        RMW_READ,
        RMW_MERGE,
        RMW_WRITE,
        ACK
    } arb_state_t;

    localparam int unsigned LANE_W  = 8;
    localparam int unsigned N_LANES = 2;

    localparam logic [1:0] STRB_LO   = 2'b01;
    localparam logic [1:0] STRB_HI   = 2'b10;
    localparam logic [1:0] STRB_FULL = 2'b11;

    // Exactly one lane strobed: the RAM has no byte enables, so this needs read-modify-write.
    function automatic logic is_partial(input logic [1:0] strb);
        return (strb == STRB_LO) || (strb == STRB_HI);
    endfunction

endpackage

// File: rtl/vram_arbiter_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
module vram_arbiter_ram #(
    parameter int unsigned DEPTH         = 256,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Contents named by MEM_INIT_FILE are loaded by the device's memory-init flow.
    if (MEM_INIT_FILE != "") begin : g_init_file
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/vram_arbiter.sv
// Character VRAM arbiter: video slots own the RAM port outright, CPU accesses
// fill the free cycles, and partial CPU writes go through read-modify-write.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter string       MEM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_en,
    input  logic                  video_slot,
    input  logic [ADDR_WIDTH-1:0] video_addr,
    output logic [DATA_WIDTH-1:0] video_data,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [1:0]            cpu_wstrb,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata
);

    arb_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] vdata_q;
    logic                  vid_pending_q;

    logic                  video_own;
    logic                  full_write;
    logic                  want_we;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign video_own  = video_en && video_slot;
    assign full_write = cpu_we && (cpu_wstrb == STRB_FULL);

    // IDLE issues directly when the port is free, so the CPU_ACCESS / RMW_READ
    // states are only entered when a video slot blocked the first attempt.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        want_we   = 1'b0;
        ram_wdata = cpu_wdata;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we && is_partial(cpu_wstrb)) begin
                        state_d = video_own ? RMW_READ : RMW_MERGE;
                    end else begin
                        state_d = video_own ? CPU_ACCESS : ACK;
                        want_we = full_write;
                    end
                end
            end
            CPU_ACCESS: begin
                if (!video_own) begin
                    state_d = ACK;
                    want_we = full_write;
                end
            end
            RMW_READ: begin
                if (!video_own) begin
                    state_d = RMW_MERGE;
                end
            end
            RMW_MERGE: begin
                for (int unsigned l = 0; l < N_LANES; l++) begin
                    merge_d[l*LANE_W +: LANE_W] = cpu_wstrb[l] ? cpu_wdata[l*LANE_W +: LANE_W]
                                                               : ram_rdata[l*LANE_W +: LANE_W];
                end
                state_d = RMW_WRITE;
            end
            RMW_WRITE: begin
                ram_wdata = merge_q;
                if (!video_own) begin
                    want_we = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_addr = video_own ? video_addr : cpu_addr;
    assign ram_we   = want_we && !video_own && !reset;

    vram_arbiter_ram #(
        .DEPTH         (2 ** ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            merge_q       <= '0;
            rdata_q       <= '0;
            vdata_q       <= '0;
            vid_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            merge_q       <= merge_d;
            vid_pending_q <= video_own;
            if (vid_pending_q) begin
                vdata_q <= ram_rdata;
            end
            if (state_q == ACK && !cpu_we) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    assign cpu_ack    = (state_q == ACK) && !reset;
    assign cpu_rdata  = (cpu_ack && !cpu_we) ? ram_rdata : rdata_q;
    assign video_data = (vid_pending_q && !reset) ? ram_rdata : vdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: latency, read-modify-write merging, video
// priority, disabled video, and reset behaviour, checked with immediate assertions.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        video_en;
    logic        video_slot;
    logic [7:0]  video_addr;
    logic [15:0] video_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [1:0]  cpu_wstrb;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    int total;
    int bad;
    int lat;
    logic [15:0] rd;

    vram_arbiter #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (16),
        .MEM_INIT_FILE ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .video_en   (video_en),
        .video_slot (video_slot),
        .video_addr (video_addr),
        .video_data (video_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU transaction; lat = cycles from request cycle to ack cycle, -1 on timeout.
    task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                           input logic [1:0] st, output int lat_o, output logic [15:0] rd_o);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_wstrb = st;
        lat_o     = -1;
        rd_o      = 16'hxxxx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                lat_o = n;
                rd_o  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        video_en   = 1'b0;
        video_slot = 1'b0;
        video_addr = '0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_wstrb  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_vdata", 32'(video_data), 32'h0);

        // Write dispatched during a reset cycle must not land; reset clears cpu_rdata.
        cpu_txn(1'b1, 8'h12, 16'h1111, 2'b11, lat, rd);
        chk("pre_wr_lat", 32'(lat), 32'd1);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("pre_rd_data", 32'(rd), 32'h1111);
        @(negedge clk);
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h12;
        cpu_wdata = 16'hDEAD;
        cpu_wstrb = 2'b11;
        @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst2_ack", 32'(cpu_ack), 32'h0);
        chk("rst2_rdata", 32'(cpu_rdata), 32'h0);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("rst_nowrite", 32'(rd), 32'h1111);

        // Full write, read back, read data held after ack.
        cpu_txn(1'b1, 8'h12, 16'hBEEF, 2'b11, lat, rd);
        chk("full_wr_lat", 32'(lat), 32'd1);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("rd_lat", 32'(lat), 32'd1);
        chk("rd_data", 32'(rd), 32'hBEEF);
        @(negedge clk);
        chk("rd_hold", 32'(cpu_rdata), 32'hBEEF);

        // Partial writes via read-modify-write.
        cpu_txn(1'b1, 8'h12, 16'h0055, 2'b01, lat, rd);
        chk("rmw_lo_lat", 32'(lat), 32'd3);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("rmw_lo_data", 32'(rd), 32'hBE55);
        cpu_txn(1'b1, 8'h12, 16'hAA00, 2'b10, lat, rd);
        chk("rmw_hi_lat", 32'(lat), 32'd3);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("rmw_hi_data", 32'(rd), 32'hAA55);

        // Zero-strobe write: acknowledged, memory untouched.
        cpu_txn(1'b1, 8'h12, 16'hFFFF, 2'b00, lat, rd);
        chk("strb0_lat", 32'(lat), 32'd1);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("strb0_data", 32'(rd), 32'hAA55);

        // Video priority.
        cpu_txn(1'b1, 8'h20, 16'h1234, 2'b11, lat, rd);
        cpu_txn(1'b1, 8'h30, 16'h5678, 2'b11, lat, rd);
        cpu_txn(1'b1, 8'h40, 16'hAB00, 2'b11, lat, rd);
        @(negedge clk);
        video_en   = 1'b1;
        video_slot = 1'b1;
        video_addr = 8'h30;
        @(negedge clk);
        video_slot = 1'b0;
        chk("vid_first", 32'(video_data), 32'h5678);

        // CPU read arriving in a slot cycle is delayed by one.
        repeat (2) @(negedge clk);
        video_slot = 1'b1;
        video_addr = 8'h20;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 8'h30;
        cpu_wstrb  = 2'b00;
        @(negedge clk);
        video_slot = 1'b0;
        chk("blk_ack_c1", 32'(cpu_ack), 32'h0);
        chk("blk_vdata", 32'(video_data), 32'h1234);
        @(negedge clk);
        chk("blk_ack_c2", 32'(cpu_ack), 32'h1);
        chk("blk_rdata", 32'(cpu_rdata), 32'h5678);
        chk("blk_vhold", 32'(video_data), 32'h1234);
        cpu_req = 1'b0;

        // CPU read issued in slot+1 must not disturb the renderer's word.
        repeat (2) @(negedge clk);
        video_slot = 1'b1;
        video_addr = 8'h30;
        @(negedge clk);
        video_slot = 1'b0;
        chk("vid_stale", 32'(video_data), 32'h5678);
        repeat (2) @(negedge clk);
        video_slot = 1'b1;
        video_addr = 8'h20;
        @(negedge clk);
        video_slot = 1'b0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 8'h30;
        chk("s1_vdata", 32'(video_data), 32'h1234);
        @(negedge clk);
        chk("s1_ack", 32'(cpu_ack), 32'h1);
        chk("s1_rdata", 32'(cpu_rdata), 32'h5678);
        chk("s1_vhold", 32'(video_data), 32'h1234);
        cpu_req = 1'b0;

        // Slot colliding with the RMW write cycle adds one cycle.
        repeat (2) @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h40;
        cpu_wdata = 16'h00CD;
        cpu_wstrb = 2'b01;
        @(negedge clk);
        chk("rmwb_ack_c1", 32'(cpu_ack), 32'h0);
        @(negedge clk);
        video_slot = 1'b1;
        video_addr = 8'h30;
        chk("rmwb_ack_c2", 32'(cpu_ack), 32'h0);
        @(negedge clk);
        video_slot = 1'b0;
        chk("rmwb_ack_c3", 32'(cpu_ack), 32'h0);
        chk("rmwb_vdata", 32'(video_data), 32'h5678);
        @(negedge clk);
        chk("rmwb_ack_c4", 32'(cpu_ack), 32'h1);
        cpu_req = 1'b0;
        cpu_txn(1'b0, 8'h40, 16'h0000, 2'b00, lat, rd);
        chk("rmwb_data", 32'(rd), 32'hABCD);

        // Video disabled: slots ignored, video_data holds.
        video_en   = 1'b0;
        video_slot = 1'b1;
        video_addr = 8'h20;
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("dis_rd_lat", 32'(lat), 32'd1);
        chk("dis_rd_data", 32'(rd), 32'hAA55);
        cpu_txn(1'b1, 8'h50, 16'h7777, 2'b11, lat, rd);
        chk("dis_wr_lat", 32'(lat), 32'd1);
        cpu_txn(1'b1, 8'h50, 16'h1100, 2'b10, lat, rd);
        chk("dis_rmw_lat", 32'(lat), 32'd3);
        cpu_txn(1'b0, 8'h50, 16'h0000, 2'b00, lat, rd);
        chk("dis_rmw_data", 32'(rd), 32'h1177);
        chk("dis_vhold", 32'(video_data), 32'h5678);
        video_slot = 1'b0;

        // Reset during RMW_MERGE aborts: no ack, no write.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 8'h12;
        cpu_wdata = 16'h0011;
        cpu_wstrb = 2'b01;
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ack", 32'(cpu_ack), 32'h0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'h0);
        lat = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (cpu_ack !== 1'b0) lat++;
        end
        chk("mid_rst_noack", 32'(lat), 32'd0);
        cpu_txn(1'b0, 8'h12, 16'h0000, 2'b00, lat, rd);
        chk("mid_rst_data", 32'(rd), 32'hAA55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
